// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: grants one command at a time,
// holds operands for SETTLE_CYCLES, then presents the captured result as a response.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,

    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_z,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_z,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e     state;
    logic [3:0] settle_cnt;
    logic       last_grant;
    logic       grant1;
    logic       accept;

    // On a tie the requester that was not served last wins.
    assign grant1     = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = (state == StIdle) & req0_valid & ~grant1;
    assign req1_ready = (state == StIdle) & grant1;
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            settle_cnt <= 4'd0;
            last_grant <= 1'b1;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_opcode <= 3'd0;
            rsp_id     <= 1'b0;
            rsp_z      <= 8'h00;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        alu_a      <= grant1 ? req1_a  : req0_a;
                        alu_b      <= grant1 ? req1_b  : req0_b;
                        alu_opcode <= grant1 ? req1_op : req0_op;
                        rsp_id     <= grant1;
                        settle_cnt <= 4'(SETTLE_CYCLES);
                        busy       <= 1'b1;
                        state      <= StExec;
                    end
                end
                StExec: begin
                    if (settle_cnt <= 4'd1) begin
                        rsp_z      <= alu_z;
                        settle_cnt <= 4'd0;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: two instances (settle 1 and 4), a behavioural ALU each,
// randomized and directed traffic, and a negedge monitor comparing responses to a queue.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] r0v, r1v, r0r, r1r, rv, rr, rid, bsy;
    logic [3:0] r0a [2];
    logic [3:0] r0b [2];
    logic [2:0] r0o [2];
    logic [3:0] r1a [2];
    logic [3:0] r1b [2];
    logic [2:0] r1o [2];
    logic [3:0] aa  [2];
    logic [3:0] ab  [2];
    logic [2:0] ao  [2];
    logic [7:0] az  [2];
    logic [7:0] rz  [2];

    typedef struct {
        logic       id;
        logic [7:0] z;
        int         acc;
    } exp_t;

    exp_t       sbq  [2][$];
    logic [8:0] rlog [2][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         outstanding [2];
    bit         lastg [2];
    bit         seen [2];
    bit         rand_rr [2];
    int         last_hs [2];
    logic [3:0] cur_a [2];
    logic [3:0] cur_b [2];
    logic [2:0] cur_o [2];
    exp_t       me;

    function automatic int settle(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Logic ops act on the raw 4-bit fields; arithmetic sign-extends to 8 bits.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0:    return 8'h00;
            3'd1:    return {4'h0, ~a};
            3'd2:    return {4'h0, a & b};
            3'd3:    return {4'h0, a | b};
            3'd4:    return {4'h0, a ^ b};
            3'd5:    return 8'(sa + sb);
            3'd6:    return 8'(sa - sb);
            default: return 8'(sa * sb);
        endcase
    endfunction

    assign az[0] = alu_ref(aa[0], ab[0], ao[0]);
    assign az[1] = alu_ref(aa[1], ab[1], ao[1]);

    alu_arbiter #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[0]), .req0_ready(r0r[0]), .req0_a(r0a[0]), .req0_b(r0b[0]),
        .req0_op(r0o[0]),
        .req1_valid(r1v[0]), .req1_ready(r1r[0]), .req1_a(r1a[0]), .req1_b(r1b[0]),
        .req1_op(r1o[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_opcode(ao[0]), .alu_z(az[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]), .rsp_z(rz[0]), .busy(bsy[0])
    );

    alu_arbiter #(.SETTLE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[1]), .req0_ready(r0r[1]), .req0_a(r0a[1]), .req0_b(r0b[1]),
        .req0_op(r0o[1]),
        .req1_valid(r1v[1]), .req1_ready(r1r[1]), .req1_a(r1a[1]), .req1_b(r1b[1]),
        .req1_op(r1o[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_opcode(ao[1]), .alu_z(az[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]), .rsp_z(rz[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h (cycle %0d)", name, d, got, exp, cyc);
        end
    endtask

    // Random rsp_ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rand_rr[d]) rr[d] = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: state/hold checks every cycle, scoreboard pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, bsy[d], outstanding[d]);
                if (outstanding[d]) begin
                    chk("ready_low", d, {r0r[d], r1r[d]}, 2'b00);
                    chk("alu_hold", d, {aa[d], ab[d], ao[d]}, {cur_a[d], cur_b[d], cur_o[d]});
                end
                if (rv[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("spurious_rsp", d, rv[d], 1'b0);
                    end else begin
                        me = sbq[d][0];
                        if (!seen[d]) begin
                            seen[d] = 1'b1;
                            chk("latency", d, cyc - me.acc, settle(d) + 1);
                        end
                        chk("rsp_id", d, rid[d], me.id);
                        chk("rsp_z", d, rz[d], me.z);
                        if (rr[d]) begin
                            void'(sbq[d].pop_front());
                            rlog[d].push_back({rid[d], rz[d]});
                            lastg[d]       = me.id;
                            outstanding[d] = 1'b0;
                            seen[d]        = 1'b0;
                            last_hs[d]     = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic set_reqs(input int d, input bit v0, input bit v1,
                            input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                            input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1);
        r0v[d] = v0; r0a[d] = a0; r0b[d] = b0; r0o[d] = o0;
        r1v[d] = v1; r1a[d] = a1; r1b[d] = b1; r1o[d] = o1;
    endtask

    task automatic issue(input int d, input bit v0, input bit v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                         input bit preset, input bit b2b, output int waited);
        int   n;
        bit   win;
        exp_t e;
        n = 0;
        if (!preset) begin
            @(posedge clk);
            #1;
        end
        set_reqs(d, v0, v1, a0, b0, o0, a1, b1, o1);
        do begin
            @(negedge clk);
            n++;
        end while (!(r0r[d] | r1r[d]) && n < 300);
        waited = n;
        if (!(r0r[d] | r1r[d])) begin
            chk("grant_timeout", d, r0r[d] | r1r[d], 1'b1);
            r0v[d] = 1'b0;
            r1v[d] = 1'b0;
            return;
        end
        win = (v0 && v1) ? !lastg[d] : v1;
        chk("grant", d, {r1r[d], r0r[d]}, win ? 2'b10 : 2'b01);
        if (b2b) chk("b2b_accept", d, cyc, last_hs[d] + 1);
        e.id  = win;
        e.z   = win ? alu_ref(a1, b1, o1) : alu_ref(a0, b0, o0);
        e.acc = cyc;
        @(posedge clk);
        sbq[d].push_back(e);
        #1;
        outstanding[d] = 1'b1;
        cur_a[d] = win ? a1 : a0;
        cur_b[d] = win ? b1 : b0;
        cur_o[d] = win ? o1 : o0;
        // Scramble requester inputs; they must not reach the held ALU operands.
        set_reqs(d, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 3'($urandom),
                 4'($urandom), 4'($urandom), 3'($urandom));
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (outstanding[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", d, outstanding[d], 1'b0);
    endtask

    task automatic reset_vals(input int d);
        chk("rst_busy", d, bsy[d], 1'b0);
        chk("rst_rsp_valid", d, rv[d], 1'b0);
        chk("rst_rsp_z", d, rz[d], 8'h00);
        chk("rst_rsp_id", d, rid[d], 1'b0);
        chk("rst_alu", d, {aa[d], ab[d], ao[d]}, 11'd0);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            outstanding[d] = 1'b0;
            lastg[d]       = 1'b1;
            seen[d]        = 1'b0;
            cur_a[d]       = 4'd0;
            cur_b[d]       = 4'd0;
            cur_o[d]       = 3'd0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         base;
        logic [1:0] v;
        rst = 1'b1;
        rr  = 2'b11;
        for (int d = 0; d < 2; d++) begin
            rand_rr[d] = 1'b0;
            last_hs[d] = 0;
            set_reqs(d, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 3'd0);
        end
        clear_model();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) reset_vals(d);
        @(posedge clk);
        #1 rst = 1'b0;

        // Tie after reset goes to req0, then strict alternation with back-to-back acceptance.
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 1'b1, 4'b0110, 4'b1101, 3'b111, 4'b0001, 4'b0011, 3'b110,
                  1'b0, i > 0, w);
        end
        wait_idle(0);
        chk("alt_cnt", 0, rlog[0].size(), 4);
        chk("alt_rsp0", 0, rlog[0][0], {1'b0, 8'hEE});
        chk("alt_rsp1", 0, rlog[0][1], {1'b1, 8'hFE});
        chk("alt_id2", 0, rlog[0][2][8], 1'b0);
        chk("alt_id3", 0, rlog[0][3][8], 1'b1);

        // Single requester ADD, settle 1.
        issue(0, 1'b1, 1'b0, 4'b0110, 4'b1101, 3'b101, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, w);
        wait_idle(0);
        chk("add_rsp", 0, rlog[0][4], {1'b0, 8'h03});

        // Response stall with a request that drops before it could be accepted.
        rr[0] = 1'b0;
        issue(0, 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'b1010, 4'b0101, 3'b011, 1'b0, 1'b0, w);
        w = 0;
        while (!rv[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("stall_reach_resp", 0, rv[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            r0v[0] = (i < 2);
            @(negedge clk);
        end
        chk("stall_hold", 0, rv[0], 1'b1);
        @(posedge clk);
        #1 rr[0] = 1'b1;
        wait_idle(0);
        repeat (4) @(negedge clk);
        chk("stall_rsp", 0, rlog[0][5], {1'b1, 8'h0F});
        chk("drop_no_cmd", 0, rlog[0].size(), 6);

        // Settle 4, XOR from req1.
        issue(1, 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'b0110, 4'b1101, 3'b100, 1'b0, 1'b0, w);
        wait_idle(1);
        chk("xor_rsp", 1, rlog[1][0], {1'b1, 8'h0B});

        // Randomized traffic on both instances with random back-pressure.
        rand_rr[0] = 1'b1;
        rand_rr[1] = 1'b1;
        fork
            begin
                int wa;
                logic [1:0] va;
                for (int i = 0; i < 40; i++) begin
                    va = 2'($urandom_range(1, 3));
                    issue(0, va[0], va[1], 4'($urandom), 4'($urandom), 3'($urandom),
                          4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, wa);
                end
            end
            begin
                int wb;
                logic [1:0] vb;
                for (int i = 0; i < 40; i++) begin
                    vb = 2'($urandom_range(1, 3));
                    issue(1, vb[0], vb[1], 4'($urandom), 4'($urandom), 3'($urandom),
                          4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, wb);
                end
            end
        join
        rand_rr[0] = 1'b0;
        rand_rr[1] = 1'b0;
        @(posedge clk);
        #1 rr = 2'b11;
        wait_idle(0);
        wait_idle(1);

        // Reset during EXEC abandons the command.
        issue(1, 1'b1, 1'b0, 4'b0111, 4'b0111, 3'b101, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, w);
        @(negedge clk);
        #2 rst = 1'b1;
        clear_model();
        @(negedge clk);
        reset_vals(1);
        reset_vals(0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 1, rv[1], 1'b0);
        end

        // Requests pending across reset release are granted on the first cycle.
        @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        set_reqs(1, 1'b1, 1'b1, 4'b0011, 4'b0010, 3'b110, 4'b0100, 4'b0100, 3'b010);
        @(posedge clk);
        #1 rst = 1'b0;
        base = rlog[1].size();
        issue(1, 1'b1, 1'b1, 4'b0011, 4'b0010, 3'b110, 4'b0100, 4'b0100, 3'b010,
              1'b1, 1'b0, w);
        chk("first_grant_wait", 1, w, 1);
        wait_idle(1);
        chk("post_rst_rsp", 1, rlog[1][base], {1'b0, 8'h01});

        // Opcode 000 still produces a response.
        issue(1, 1'b0, 1'b1, 4'd0, 4'd0, 3'd0, 4'b1111, 4'b1111, 3'b000, 1'b0, 1'b0, w);
        wait_idle(1);
        chk("nop_rsp", 1, rlog[1][base + 1], {1'b1, 8'h00});

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("sb_empty", d, sbq[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of EXEC cycles the shared ALU is given before its result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a command pending.
REQ-005 req0_ready  output  1  requester 0 command accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  4 each  signed operands, requester 0.
REQ-007 req0_op  input  3  ALU opcode, requester 0 (000 nop, 001 NOT A, 010 AND, 011 OR, 100 XOR, 101 ADD, 110 SUB, 111 MUL).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions, widths and meaning, requester 1.
REQ-009 alu_a, alu_b  output  4 each  operands driven to the shared ALU.
REQ-010 alu_opcode  output  3  opcode driven to the shared ALU.
REQ-011 alu_z  input  8  ALU result, combinational from alu_a/alu_b/alu_opcode.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response when high with rsp_valid.
REQ-014 rsp_id  output  1  requester that issued the responded command.
REQ-015 rsp_z  output  8  captured ALU result.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-018 reqN_ready is combinational: high only in IDLE, only for the granted requester; never both high.
REQ-019 Grant in IDLE: single valid requester wins; both valid -> requester not served last (last_grant pointer) wins.
REQ-020 Acceptance (valid & ready): alu_a/alu_b/alu_opcode and rsp_id registered from winner, settle counter loaded with SETTLE_CYCLES, next state EXEC.
REQ-021 EXEC lasts exactly SETTLE_CYCLES cycles; on its last cycle rsp_z <= alu_z, next state RESP.
REQ-022 alu_a/alu_b/alu_opcode held constant from acceptance until the next acceptance; reqN_* changes after acceptance have no effect.
REQ-023 RESP: rsp_valid high, rsp_z and rsp_id stable until rsp_valid & rsp_ready; then last_grant <= rsp_id, next state IDLE.
REQ-024 Latency: rsp_valid first high SETTLE_CYCLES+1 cycles after the acceptance edge; with rsp_ready held high, next acceptance possible the cycle after the response handshake.
REQ-025 rsp_ready low -> RESP held indefinitely; no new command accepted; both reqN_ready low.
REQ-026 reqN_valid dropped before acceptance -> no command recorded, no grant change.
REQ-027 alu_z passed to rsp_z verbatim; no sign extension, saturation or opcode checking in this block.
REQ-028 Opcode 000 is sequenced like any other command and produces a response.

Reset
REQ-029 rst high: state IDLE, settle counter 0, alu_a/alu_b/alu_opcode 0, rsp_z 8'h00, rsp_id 0, rsp_valid 0, busy 0, last_grant = 1 (requester 0 wins first tie).
REQ-030 rst asserted in EXEC or RESP abandons the command immediately; no response produced after reset release.
REQ-031 First grant possible in first cycle after rst deasserts.

Verification (bench uses behavioural ALU model: 8-bit two's complement result, sign-extended operands)
REQ-032 SETTLE_CYCLES=1, req0 ADD A=0110 B=1101, rsp_ready=1 -> rsp_valid 2 cycles after acceptance, rsp_id=0, rsp_z=8'h03, busy high 2 cycles.
REQ-033 Both valid after reset, req0 MUL 0110*1101, req1 SUB 0001-0011 -> req0 served first rsp_z=8'hEE, then req1 rsp_z=8'hFE; repeated both-valid alternates 0,1,0,1.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_z/rsp_id stable, req0_ready and req1_ready low, alu_* unchanged; response completes when rsp_ready rises.
REQ-035 SETTLE_CYCLES=4, req1 XOR 0110^1101, operands changed during EXEC -> rsp_z=8'h0B, latency 5 cycles, alu_* unchanged during EXEC.
REQ-036 rst pulsed during EXEC -> all outputs at reset values, no rsp_valid afterwards until a new acceptance.
